// File: rtl/ads_frame_packer.sv
`default_nettype none
// ads_frame_packer: buffers whole 80-word ADS bursts and emits them as framed
// packets (sync, header, payload, checksum) on an AXI-Stream-style master.
module ads_frame_packer #(
    parameter int          BURST_WORDS = 80,
    parameter int          FIFO_DEPTH  = 256,
    parameter logic [31:0] SYNC_WORD   = 32'hA5A5_5A5A
) (
    input  logic        clk_ps,
    input  logic        rst_n,
    input  logic        data_valid,
    input  logic [31:0] data,
    input  logic        m_tready,
    output logic        m_tvalid,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    output logic [15:0] drop_cnt,
    output logic [8:0]  fifo_level
);
    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam int            CW        = $clog2(BURST_WORDS);
    localparam logic [CW-1:0] LAST_WORD = CW'(BURST_WORDS - 1);
    localparam logic [8:0]    ADMIT_MAX = 9'(FIFO_DEPTH - BURST_WORDS);
    localparam logic [15:0]   HDR_LEN   = 16'(BURST_WORDS);

    typedef enum logic [2:0] {IDLE, SYNC, HDR, PAY, CSUM} state_t;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_p1;
    logic [CW-1:0] in_cnt;
    logic          burst_admit;
    logic [8:0]    frames_ready;
    logic          fits;
    logic          admit;
    logic          wr_en;
    logic          burst_done;
    logic          pop;
    logic          csum_done;
    logic          xfer;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_cnt_nxt;
    logic [31:0]   csum;
    logic [31:0]   csum_nxt;
    logic [15:0]   seq;
    logic [15:0]   seq_nxt;
    logic [15:0]   drop_nxt;
    logic          tvalid_nxt;
    logic          tlast_nxt;
    logic [31:0]   tdata_nxt;

    // The decision taken on the first word of a burst is held for the rest of it.
    assign fits       = (fifo_level <= ADMIT_MAX);
    assign admit      = (in_cnt == '0) ? fits : burst_admit;
    assign wr_en      = data_valid & admit;
    assign burst_done = wr_en & (in_cnt == LAST_WORD);
    assign drop_nxt   = (data_valid && (in_cnt == '0) && !fits && (drop_cnt != 16'hFFFF))
                        ? drop_cnt + 16'd1 : drop_cnt;
    assign xfer       = m_tvalid & m_tready;
    assign rd_ptr_p1  = rd_ptr + 1'b1;

    always_ff @(posedge clk_ps or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt      <= '0;
            burst_admit <= 1'b0;
            wr_ptr      <= '0;
        end else if (data_valid) begin
            in_cnt      <= (in_cnt == LAST_WORD) ? '0 : in_cnt + 1'b1;
            burst_admit <= admit;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ps) begin
        if (wr_en) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk_ps or negedge rst_n) begin
        if (!rst_n) begin
            fifo_level   <= '0;
            frames_ready <= '0;
        end else begin
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + 9'd1;
                2'b01:   fifo_level <= fifo_level - 9'd1;
                default: ;
            endcase
            case ({burst_done, csum_done})
                2'b10:   frames_ready <= frames_ready + 9'd1;
                2'b01:   frames_ready <= frames_ready - 9'd1;
                default: ;
            endcase
        end
    end

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        state_nxt   = state;
        tvalid_nxt  = m_tvalid;
        tdata_nxt   = m_tdata;
        tlast_nxt   = m_tlast;
        out_cnt_nxt = out_cnt;
        csum_nxt    = csum;
        seq_nxt     = seq;
        pop         = 1'b0;
        csum_done   = 1'b0;
        case (state)
            IDLE: begin
                if (frames_ready != '0) begin
                    state_nxt  = SYNC;
                    tvalid_nxt = 1'b1;
                    tdata_nxt  = SYNC_WORD;
                end
            end
            SYNC: begin
                if (xfer) begin
                    state_nxt = HDR;
                    tdata_nxt = {seq, HDR_LEN};
                end
            end
            HDR: begin
                if (xfer) begin
                    state_nxt   = PAY;
                    tdata_nxt   = mem[rd_ptr];
                    out_cnt_nxt = '0;
                    csum_nxt    = '0;
                end
            end
            PAY: begin
                if (xfer) begin
                    pop      = 1'b1;
                    csum_nxt = csum + m_tdata;
                    if (out_cnt == LAST_WORD) begin
                        state_nxt = CSUM;
                        tdata_nxt = csum + m_tdata;
                        tlast_nxt = 1'b1;
                    end else begin
                        out_cnt_nxt = out_cnt + 1'b1;
                        tdata_nxt   = mem[rd_ptr_p1];
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_nxt  = IDLE;
                    tvalid_nxt = 1'b0;
                    tlast_nxt  = 1'b0;
                    seq_nxt    = seq + 16'd1;
                    csum_done  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_ps or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            out_cnt  <= '0;
            csum     <= '0;
            seq      <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            m_tvalid <= tvalid_nxt;
            m_tdata  <= tdata_nxt;
            m_tlast  <= tlast_nxt;
            out_cnt  <= out_cnt_nxt;
            csum     <= csum_nxt;
            seq      <= seq_nxt;
            drop_cnt <= drop_nxt;
            if (pop) begin
                rd_ptr <= rd_ptr_p1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ads_frame_packer.md
# ads_frame_packer

Packs the 80-word ADS burst stream produced by the RAM read controller (`data_valid`/`data`, 10 channels × 8 words) into framed packets for the PS-side DMA. It buffers the payload in a FIFO and wraps each burst with a sync word, a header and a checksum trailer. It drives an AXI-Stream-style master with backpressure. The upstream stage has no flow control, so bursts are admitted whole or dropped whole.

## Interface
- BURST_WORDS, 80, payload words per burst (10 ch × 8)
- FIFO_DEPTH, 256, payload FIFO depth in words; power of 2; must be ≥ BURST_WORDS
- SYNC_WORD, 32'hA5A5_5A5A, first word of every frame
- clk_ps  in  1  system clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- data_valid  in  1  upstream payload word strobe
- data  in  32  upstream payload word, sampled when data_valid=1
- m_tready  in  1  downstream ready
- m_tvalid  out  1  output word valid
- m_tdata  out  32  output word
- m_tlast  out  1  high on the checksum word (last word of frame)
- drop_cnt  out  16  number of dropped bursts, saturating
- fifo_level  out  9  payload words currently stored (0..FIFO_DEPTH)

## Operation
- Input side:
  - in_cnt (0..BURST_WORDS-1) counts accepted or discarded words of the current burst.
  - Burst boundaries are defined only by the count. in_cnt advances on every data_valid and wraps to 0 after BURST_WORDS-1.
  - Admission: on data_valid with in_cnt=0, the burst is admitted if (FIFO_DEPTH − fifo_level) ≥ BURST_WORDS. Otherwise the whole burst is discarded.
  - A discarded burst increments drop_cnt by 1, saturating at 16'hFFFF. The admit/discard decision is held for all BURST_WORDS words of that burst.
  - Admitted words are written to the FIFO in order. The FIFO never overflows.
  - frames_ready counter: +1 when the last word of an admitted burst is written; −1 when a checksum word is transferred; unchanged if both happen in the same cycle.
- Output FSM, states IDLE, SYNC, HDR, PAY, CSUM:
  - IDLE → SYNC when frames_ready > 0.
  - SYNC: m_tdata=SYNC_WORD. → HDR on transfer.
  - HDR: m_tdata={seq[15:0], BURST_WORDS[15:0]}. → PAY on transfer; out_cnt cleared, csum cleared.
  - PAY: m_tdata=FIFO head. Each transfer pops one word, csum += word (mod 2^32), out_cnt++. → CSUM after transfer of word BURST_WORDS-1.
  - CSUM: m_tdata=csum, m_tlast=1. On transfer: seq++ (wraps 0xFFFF→0), → IDLE.
- A transfer is m_tvalid & m_tready. m_tvalid=1 in SYNC/HDR/PAY/CSUM and 0 in IDLE.
- While m_tvalid=1 and m_tready=0, m_tdata and m_tlast stay stable.
- Dropped bursts do not consume a seq value.
- fifo_level: +1 on write, −1 on pop, unchanged on simultaneous write and pop.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, drop_cnt=0, fifo_level=0; also seq=0, in_cnt=0, frames_ready=0, state=IDLE.
- Reset asserted mid-frame discards FIFO contents and any partial frame. The input burst alignment restarts at in_cnt=0.
- All outputs are registered.
- Latency: the 80th payload word is sampled at edge N. frames_ready=1 after edge N. m_tvalid=1 with SYNC_WORD after edge N+1 (IDLE case).
- With m_tready held at 1, a frame occupies exactly BURST_WORDS+3 = 83 consecutive cycles. The next frame follows after 1 IDLE cycle if frames_ready>0.
- FIFO read is show-ahead. PAY can sustain one word per cycle under continuous m_tready.
- PAY may run concurrently with FIFO writes of the next burst.
- fifo_level is updated in the cycle after the write/pop edge and is what the admission check uses. The admission check includes a pop occurring in the same cycle only via the next-cycle level; conservative by ≤1 word.

## Test plan
- Single burst, data = 0..79, m_tready=1 -> 83 words: A5A55A5A, 0x00000050, 0..79, checksum 0x00000C58 (sum 3160) with m_tlast. SYNC appears 2 cycles after the last input word.
- Three back-to-back bursts, m_tready=1 -> three frames with headers 0x00000050, 0x00010050, 0x00020050. drop_cnt=0. fifo_level never exceeds 160.
- m_tready=0 during four bursts (FIFO_DEPTH=256) -> bursts 1–3 admitted (fifo_level=240), burst 4 dropped, drop_cnt=1. After releasing m_tready, exactly 3 frames are emitted with seq 0,1,2.
- Random m_tready (50% duty) over 10 bursts with random data -> every frame has correct sync/header/checksum. m_tdata is stable under stall. No word is lost or duplicated.
- seq preloaded via 65536 frames (or a forced value of 0xFFFF) -> header after 0xFFFF reads 0x00000050. drop_cnt forced to 0xFFFF plus one more drop -> stays 0xFFFF.
- rst_n pulsed low at payload word 40 of an output frame -> all outputs return to reset values immediately. The next full burst produces a frame with seq=0 and a correct checksum.
